ram_sync_read_nway: RTL

- N-way data RAM for the L1 set-associative cache.
- One shared set address selects a set. A read returns all ways in parallel so the tag and way-select logic can compare them.
- Writes target one or more ways, with byte enables.
- After reset, a built-in clear sequencer zeroes the whole array before the block accepts any request. This removes the need for file-based memory initialisation.

---
 rtl/ram_pkg.sv | 32 +++
 rtl/ram_way_bank.sv | 64 ++++++
 rtl/ram_sync_read_nway.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types and helpers for the N-way synchronous-read data RAM.
//            Optional feature macro: RAM_NWAY_PARITY_EN (byte parity helper).
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Sequencer states: CLEAR zeroes the array, READY serves requests
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Number of sets addressed by an aw-bit set address
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Number of byte lanes in a dw-bit word
  function automatic int bwidth_of(input int dw);
    return dw / 8;
  endfunction

  // Even-parity bit of one byte (XOR of all bits)
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_way_bank.sv
`default_nettype none
// ============================================================================
// Module   : ram_way_bank
// Purpose  : One way of the data RAM: DEPTH x DWIDTH array with byte-enable
//            write and a read port on the shared set address.
//            Optional feature macro: RAM_NWAY_PARITY_EN adds per-byte parity
//            storage and a per-way parity error flag on the read data.
// Revision : 1.0 - initial release
// ============================================================================
module ram_way_bank
  import ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic [DWIDTH-1:0]     din,
`ifdef RAM_NWAY_PARITY_EN
  output logic                  par_err,
`endif
  output logic [DWIDTH-1:0]     rd_data
);

  localparam int DEPTH  = depth_of(AWIDTH);
  localparam int BWIDTH = bwidth_of(DWIDTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Byte-lane write; the array itself has no reset, the top-level clear
  // sequencer zeroes it after every reset
  always_ff @(posedge clock) begin
    for (int b = 0; b < BWIDTH; b++) begin
      if (we && be[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
    end
  end

  // The top registers this value into dout, so the read data here is a
  // plain array lookup on the (registered-at-the-edge) set address
  assign rd_data = mem[addr];

`ifdef RAM_NWAY_PARITY_EN
  logic [BWIDTH-1:0] par_mem [DEPTH];

  // Parity bit travels with its byte, including the all-zero clear writes
  always_ff @(posedge clock) begin
    for (int b = 0; b < BWIDTH; b++) begin
      if (we && be[b]) par_mem[addr][b] <= byte_parity(din[b*8 +: 8]);
    end
  end

  // Any byte whose recomputed parity disagrees with the stored bit flags the way
  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < BWIDTH; b++) begin
      par_err = par_err | (byte_parity(rd_data[b*8 +: 8]) ^ par_mem[addr][b]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ram_sync_read_nway.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_read_nway
// Purpose  : N-way data RAM for the L1 set-associative cache. A read returns
//            all ways of one set in parallel one cycle later; writes hit any
//            subset of ways with byte enables. A clear sequencer zeroes the
//            array after reset before requests are accepted.
//            Optional feature macro: RAM_NWAY_PARITY_EN (per-byte parity,
//            parity_err output).
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync_read_nway
  import ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int NWAYS  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [AWIDTH-1:0]         addr,
  input  logic [NWAYS-1:0]          way_sel,
  input  logic [DWIDTH/8-1:0]       be,
  input  logic [DWIDTH-1:0]         din,
  output logic [NWAYS*DWIDTH-1:0]   dout,
  output logic                      dout_valid,
`ifdef RAM_NWAY_PARITY_EN
  output logic [NWAYS-1:0]          parity_err,
`endif
  output logic                      ready
);

  localparam int                 DEPTH  = depth_of(AWIDTH);
  localparam int                 BWIDTH = bwidth_of(DWIDTH);
  localparam logic [AWIDTH-1:0]  LAST   = AWIDTH'(DEPTH - 1);

  state_t                    state;
  logic [AWIDTH-1:0]         clr_cnt;
  logic                      clearing;
  logic                      rd_accept;
  logic                      wr_accept;
  logic [AWIDTH-1:0]         bank_addr;
  logic [BWIDTH-1:0]         bank_be;
  logic [DWIDTH-1:0]         bank_din;
  logic [NWAYS-1:0]          bank_we;
  logic [NWAYS*DWIDTH-1:0]   rd_all;
`ifdef RAM_NWAY_PARITY_EN
  logic [NWAYS-1:0]          rd_par_err;
`endif

  assign clearing  = (state == CLEAR);
  assign rd_accept = (state == READY) && req && !we;
  assign wr_accept = (state == READY) && req && we;

  // While clearing, the sequencer owns the array: every way, every byte, data 0
  always_comb begin
    bank_addr = addr;
    bank_be   = be;
    bank_din  = din;
    bank_we   = {NWAYS{wr_accept}} & way_sel;
    if (clearing) begin
      bank_addr = clr_cnt;
      bank_be   = '1;
      bank_din  = '0;
      bank_we   = '1;
    end
  end

  for (genvar k = 0; k < NWAYS; k++) begin : g_way
    ram_way_bank #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
    ) u_bank (
      .clock   (clock),
      .we      (bank_we[k]),
      .addr    (bank_addr),
      .be      (bank_be),
      .din     (bank_din),
`ifdef RAM_NWAY_PARITY_EN
      .par_err (rd_par_err[k]),
`endif
      .rd_data (rd_all[k*DWIDTH +: DWIDTH])
    );
  end

  // Clear sequencer plus registered read outputs; dout only moves on an
  // accepted read so later writes never disturb a returned line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      ready      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef RAM_NWAY_PARITY_EN
      parity_err <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AWIDTH'(1);
          if (clr_cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (rd_accept) begin
            dout       <= rd_all;
            dout_valid <= 1'b1;
`ifdef RAM_NWAY_PARITY_EN
            parity_err <= rd_par_err;
`endif
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
